// File: rtl/syn_pkg.sv
// Shared definitions for the synapse weight bank.
//   syn_state_t      : controller state encoding
//   SYN_*_DEF        : default parameter values for syn_weight_bank
//   SYN_LFSR_TAPS    : feedback taps of the 8-bit random generator
//   lfsr_next()      : one generator step
package syn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_RSP  = 2'd2,
      ST_CLR  = 2'd3
   } syn_state_t;

   localparam int         SYN_N_SYN_DEF     = 128;
   localparam int         SYN_COL_W_DEF     = 8;
   localparam int         SYN_NUM_COL_DEF   = 4;
   localparam int         SYN_RC_DEPTH_DEF  = 4;
   localparam logic [7:0] SYN_LFSR_SEED_DEF = 8'hA5;

   // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: feedback from bits 7, 5, 4, 3
   localparam logic [7:0] SYN_LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & SYN_LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/syn_rc_cam.sv
// Rich-club decimal weight table: a small fully associative store of
// (synapse tag, decimal weight) pairs with valid bits and round-robin
// replacement once every entry is in use.
// Ports:
//   clk, rst     clock, async active-low reset (clears valid bits and pointer)
//   clr          synchronous clear of valid bits and pointer
//   wr_en        write wr_data under tag lk_tag
//   lk_tag       tag used for both lookup and write
//   wr_data      decimal weight to store
//   hit          lk_tag matches a valid entry
//   hit_data     data of the matching entry (lowest index if several)
//   full         every entry valid
module syn_rc_cam
   import syn_pkg::*;
#(
   parameter int TAG_W  = 7,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [TAG_W-1:0]  lk_tag,
   input  logic [DATA_W-1:0] wr_data,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   output logic              full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [PW-1:0]     rr_q;
   logic [PW-1:0]     hit_idx;
   logic [PW-1:0]     free_idx;
   logic [PW-1:0]     wr_idx;

   // Descending scans so the lowest matching / free index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vld_q[i] && (tag_q[i] == lk_tag)) begin
            hit     = 1'b1;
            hit_idx = PW'(i);
         end
         if (!vld_q[i]) begin
            free_idx = PW'(i);
         end
      end
   end

   assign full     = &vld_q;
   assign hit_data = data_q[hit_idx];
   assign wr_idx   = hit ? hit_idx : (full ? rr_q : free_idx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         rr_q  <= '0;
      end else if (clr) begin
         vld_q <= '0;
         rr_q  <= '0;
      end else if (wr_en) begin
         vld_q[wr_idx] <= 1'b1;
         if (!hit && full) begin
            rr_q <= (rr_q == PW'(DEPTH - 1)) ? '0 : rr_q + 1'b1;
         end
      end
   end

   // Tags and data are qualified by vld_q, so they need no reset.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         tag_q[wr_idx]  <= lk_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/syn_weight_bank.sv
// Synapse weight bank: integer weights in a byte-lane block RAM, decimal
// weights from the rich-club table or, on a miss, from an 8-bit LFSR.
// Writes finish in IDLE in one cycle; reads return two cycles after accept.
// Ports:
//   clk, rst                clock, async active-low reset
//   kill                    synchronous clear of table and response registers
//   req_valid/req_ready     request handshake
//   req_we, req_rc          write/read select, target rich-club table
//   req_addr                synapse index
//   req_wint, req_wdeci     integer / decimal weight to write
//   rsp_valid               one-cycle read data strobe
//   rsp_weight, rsp_hit     {integer, decimal} result, decimal came from table
//   rc_full                 rich-club table has no free entry
//
// state | meaning
// IDLE  | accepting requests; writes complete here
// RD    | RAM word and table lookup available, response is built
// RSP   | rsp_valid high, response registers loaded
// CLR   | one cycle after kill, nothing accepted
module syn_weight_bank
   import syn_pkg::*;
#(
   parameter int         N_SYN     = SYN_N_SYN_DEF,
   parameter int         COL_W     = SYN_COL_W_DEF,
   parameter int         NUM_COL   = SYN_NUM_COL_DEF,
   parameter int         RC_DEPTH  = SYN_RC_DEPTH_DEF,
   parameter logic [7:0] LFSR_SEED = SYN_LFSR_SEED_DEF
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     kill,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic                     req_rc,
   input  logic [$clog2(N_SYN)-1:0] req_addr,
   input  logic [COL_W-1:0]         req_wint,
   input  logic [COL_W-1:0]         req_wdeci,
   output logic                     rsp_valid,
   output logic [2*COL_W-1:0]       rsp_weight,
   output logic                     rsp_hit,
   output logic                     rc_full
);

   localparam int AW = $clog2(N_SYN);
   localparam int LW = $clog2(NUM_COL);
   localparam int RW = AW - LW;

   syn_state_t state_q, state_n;

   logic [AW-1:0] rd_addr_q;
   logic          rd_rc_q;
   logic [7:0]    lfsr_q;
   logic [7:0]    lfsr_nx;

   logic          accept, wr_acc, rd_acc;
   logic [RW-1:0] row;
   logic [LW-1:0] lane;
   logic [LW-1:0] rd_lane;

   logic [AW-1:0]    lk_tag;
   logic             cam_hit;
   logic [COL_W-1:0] cam_data;
   logic             rd_hit;

   logic [NUM_COL-1:0][COL_W-1:0] ram [N_SYN/NUM_COL];
   logic [NUM_COL-1:0][COL_W-1:0] ram_q;

   always_comb begin
      state_n   = state_q;
      req_ready = 1'b0;
      if (kill) begin
         state_n = ST_CLR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               req_ready = rst;
               if (req_valid && !req_we) state_n = ST_RD;
            end
            ST_RD:   state_n = ST_RSP;
            ST_RSP:  state_n = ST_IDLE;
            ST_CLR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   assign accept  = req_valid && req_ready;
   assign wr_acc  = accept && req_we;
   assign rd_acc  = accept && !req_we;
   assign row     = req_addr[AW-1:LW];
   assign lane    = req_addr[LW-1:0];
   assign rd_lane = rd_addr_q[LW-1:0];
   assign lfsr_nx = lfsr_next(lfsr_q);

   // The table sees the write address in IDLE and the latched read address
   // in RD; the two never overlap because only one request is in flight.
   assign lk_tag = (state_q == ST_RD) ? rd_addr_q : req_addr;
   assign rd_hit = rd_rc_q && cam_hit;

   syn_rc_cam #(
      .TAG_W  (AW),
      .DATA_W (COL_W),
      .DEPTH  (RC_DEPTH)
   ) u_rc_cam (
      .clk      (clk),
      .rst      (rst),
      .clr      (kill),
      .wr_en    (wr_acc && req_rc),
      .lk_tag   (lk_tag),
      .wr_data  (req_wdeci),
      .hit      (cam_hit),
      .hit_data (cam_data),
      .full     (rc_full)
   );

   // Byte-lane write, registered read; no reset so it maps to block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_COL; i++) begin
         if (wr_acc && (lane == LW'(i))) ram[row][i] <= req_wint;
      end
      if (rd_acc) ram_q <= ram[row];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rd_addr_q  <= '0;
         rd_rc_q    <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         rsp_valid  <= 1'b0;
         rsp_weight <= '0;
         rsp_hit    <= 1'b0;
      end else begin
         state_q   <= state_n;
         rsp_valid <= 1'b0;
         if (rd_acc) begin
            rd_addr_q <= req_addr;
            rd_rc_q   <= req_rc;
         end
         if (kill) begin
            rsp_weight <= '0;
            rsp_hit    <= 1'b0;
         end else if (state_q == ST_RD) begin
            rsp_valid  <= 1'b1;
            rsp_hit    <= rd_hit;
            rsp_weight <= {ram_q[rd_lane], rd_hit ? cam_data : COL_W'(lfsr_nx)};
            if (!rd_hit) lfsr_q <= lfsr_nx;
         end
      end
   end

endmodule

// File: tb/tb_syn_weight_bank.sv
// Self-checking bench for syn_weight_bank: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the bank.
module tb_syn_weight_bank;

   localparam int N_SYN    = 128;
   localparam int COL_W    = 8;
   localparam int NUM_COL  = 4;
   localparam int RC_DEPTH = 4;
   localparam int AW       = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          kill = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic          req_rc = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_wint = '0;
   logic [7:0]    req_wdeci = '0;
   logic          req_ready, rsp_valid, rsp_hit, rc_full;
   logic [15:0]   rsp_weight;

   always #5 clk = ~clk;

   syn_weight_bank #(
      .N_SYN     (N_SYN),
      .COL_W     (COL_W),
      .NUM_COL   (NUM_COL),
      .RC_DEPTH  (RC_DEPTH),
      .LFSR_SEED (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .kill       (kill),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_rc     (req_rc),
      .req_addr   (req_addr),
      .req_wint   (req_wint),
      .req_wdeci  (req_wdeci),
      .rsp_valid  (rsp_valid),
      .rsp_weight (rsp_weight),
      .rsp_hit    (rsp_hit),
      .rc_full    (rc_full)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]    m_mem  [N_SYN];
   logic [AW-1:0] m_tag  [RC_DEPTH];
   logic [7:0]    m_data [RC_DEPTH];
   bit            m_vld  [RC_DEPTH];
   int            m_rr;
   logic [7:0]    m_lfsr;
   bit            m_pend;
   logic [AW-1:0] m_paddr;
   bit            m_prc;
   bit            m_clr;
   bit            e_valid;
   logic [15:0]   e_weight;
   bit            e_hit;
   bit            e_ready;
   bit            e_full;
   int            m_idx;
   logic [7:0]    m_deci;

   function automatic logic [7:0] ref_step(input logic [7:0] v);
      // x^8 + x^6 + x^5 + x^4 + 1: shift left, new LSB = v7^v5^v4^v3
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic int find_tag(input logic [AW-1:0] a);
      for (int i = 0; i < RC_DEPTH; i++)
         if (m_vld[i] && m_tag[i] == a) return i;
      return -1;
   endfunction

   function automatic int find_free();
      for (int i = 0; i < RC_DEPTH; i++)
         if (!m_vld[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_valid",  {31'd0, rsp_valid}, 32'd0);
         chk("rst_weight", {16'd0, rsp_weight}, 32'd0);
         chk("rst_hit",    {31'd0, rsp_hit},   32'd0);
         chk("rst_full",   {31'd0, rc_full},   32'd0);
         chk("rst_ready",  {31'd0, req_ready}, 32'd0);
         for (int i = 0; i < RC_DEPTH; i++) m_vld[i] = 1'b0;
         m_rr = 0; m_lfsr = 8'hA5; m_pend = 1'b0; m_clr = 1'b0;
         e_valid = 1'b0; e_weight = '0; e_hit = 1'b0;
      end else begin
         e_full = 1'b1;
         for (int i = 0; i < RC_DEPTH; i++) if (!m_vld[i]) e_full = 1'b0;
         e_ready = !kill && !m_pend && !e_valid && !m_clr;
         chk("cyc_valid",  {31'd0, rsp_valid}, {31'd0, e_valid});
         chk("cyc_weight", {16'd0, rsp_weight}, {16'd0, e_weight});
         chk("cyc_hit",    {31'd0, rsp_hit},   {31'd0, e_hit});
         chk("cyc_full",   {31'd0, rc_full},   {31'd0, e_full});
         chk("cyc_ready",  {31'd0, req_ready}, {31'd0, e_ready});
         // predict the state after the coming rising edge
         e_valid = 1'b0;
         m_clr   = 1'b0;
         if (kill) begin
            for (int i = 0; i < RC_DEPTH; i++) m_vld[i] = 1'b0;
            m_rr = 0; m_pend = 1'b0; m_clr = 1'b1;
            e_weight = '0; e_hit = 1'b0;
         end else if (m_pend) begin
            m_idx = m_prc ? find_tag(m_paddr) : -1;
            if (m_idx >= 0) begin
               m_deci = m_data[m_idx];
               e_hit  = 1'b1;
            end else begin
               m_lfsr = ref_step(m_lfsr);
               m_deci = m_lfsr;
               e_hit  = 1'b0;
            end
            e_weight = {m_mem[m_paddr], m_deci};
            e_valid  = 1'b1;
            m_pend   = 1'b0;
         end else if (req_valid && e_ready) begin
            if (req_we) begin
               m_mem[req_addr] = req_wint;
               if (req_rc) begin
                  m_idx = find_tag(req_addr);
                  if (m_idx < 0) m_idx = find_free();
                  if (m_idx < 0) begin
                     m_idx = m_rr;
                     m_rr  = (m_rr + 1) % RC_DEPTH;
                  end
                  m_tag[m_idx]  = req_addr;
                  m_data[m_idx] = req_wdeci;
                  m_vld[m_idx]  = 1'b1;
               end
            end else begin
               m_pend  = 1'b1;
               m_paddr = req_addr;
               m_prc   = req_rc;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_wr(input logic [AW-1:0] a, input logic [7:0] wi,
                        input logic [7:0] wd, input logic rc);
      req_valid = 1'b1; req_we = 1'b1; req_rc = rc;
      req_addr = a; req_wint = wi; req_wdeci = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_rc = 1'b0;
   endtask

   task automatic do_rd(input logic [AW-1:0] a, input logic rc,
                        output logic [15:0] w, output logic h);
      bit got;
      req_valid = 1'b1; req_we = 1'b0; req_rc = rc; req_addr = a;
      @(posedge clk); #1;
      req_valid = 1'b0; req_rc = 1'b0;
      got = 1'b0; w = 'x; h = 1'bx;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            got = 1'b1; w = rsp_weight; h = rsp_hit;
         end
      end
      if (!got) chk("rd_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_full(input string name, input logic exp);
      @(negedge clk);
      chk(name, {31'd0, rc_full}, {31'd0, exp});
      @(posedge clk); #1;
   endtask

   logic [15:0] w;
   logic        h;
   int          op;
   logic [AW-1:0] ra;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int a = 0; a < N_SYN; a++) do_wr(AW'(a), 8'($urandom), 8'($urandom), 1'b0);

      // first miss after reset returns one LFSR step from A5 (= 4A)
      do_wr(7'd5, 8'h3C, 8'h00, 1'b0);
      do_rd(7'd5, 1'b0, w, h);
      chk("rd5_weight", {16'd0, w}, 32'h3C4A);
      chk("rd5_hit", {31'd0, h}, 32'd0);

      // byte-lane writes do not disturb neighbours
      do_wr(7'd4, 8'h11, 8'h00, 1'b0);
      do_wr(7'd5, 8'h22, 8'h00, 1'b0);
      do_wr(7'd6, 8'h33, 8'h00, 1'b0);
      do_wr(7'd7, 8'h44, 8'h00, 1'b0);
      do_rd(7'd6, 1'b0, w, h); chk("lane6", {24'd0, w[15:8]}, 32'h33);
      do_rd(7'd4, 1'b0, w, h); chk("lane4", {24'd0, w[15:8]}, 32'h11);
      do_rd(7'd5, 1'b0, w, h); chk("lane5", {24'd0, w[15:8]}, 32'h22);
      do_rd(7'd7, 1'b0, w, h); chk("lane7", {24'd0, w[15:8]}, 32'h44);

      // fill the table, then round-robin replacement of entry 0
      do_wr(7'd10, 8'hA1, 8'd1, 1'b1);
      do_wr(7'd20, 8'hA2, 8'd2, 1'b1);
      do_wr(7'd30, 8'hA3, 8'd3, 1'b1);
      do_wr(7'd40, 8'hA4, 8'd4, 1'b1);
      check_full("full_after4", 1'b1);
      do_wr(7'd50, 8'hA5, 8'd9, 1'b1);
      do_rd(7'd10, 1'b1, w, h); chk("rd10_evicted_hit", {31'd0, h}, 32'd0);
      do_rd(7'd50, 1'b1, w, h);
      chk("rd50_deci", {24'd0, w[7:0]}, 32'd9);
      chk("rd50_hit", {31'd0, h}, 32'd1);

      // repeated write to same tag overwrites in place
      do_wr(7'd20, 8'hB2, 8'd7, 1'b1);
      do_wr(7'd20, 8'hB2, 8'd7, 1'b1);
      check_full("full_rewrite", 1'b1);
      do_rd(7'd20, 1'b1, w, h);
      chk("rd20_deci", {24'd0, w[7:0]}, 32'd7);
      chk("rd20_hit", {31'd0, h}, 32'd1);

      // kill in the RD cycle drops the read and empties the table
      do_wr(7'd12, 8'h77, 8'h5A, 1'b1);
      req_valid = 1'b1; req_we = 1'b0; req_rc = 1'b1; req_addr = 7'd12;
      @(posedge clk); #1;
      req_valid = 1'b0; req_rc = 1'b0; kill = 1'b1;
      @(negedge clk);
      chk("kill_rd_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1 kill = 1'b0;
      @(negedge clk);
      chk("kill_clr_valid", {31'd0, rsp_valid}, 32'd0);
      chk("kill_clr_full", {31'd0, rc_full}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("kill_no_late_rsp", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      do_rd(7'd12, 1'b1, w, h);
      chk("rd12_hit_after_kill", {31'd0, h}, 32'd0);
      chk("rd12_int_kept", {24'd0, w[15:8]}, 32'h77);

      // asynchronous reset during RSP
      req_valid = 1'b1; req_we = 1'b0; req_rc = 1'b0; req_addr = 7'd5;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rsp_before_rst", {31'd0, rsp_valid}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid",  {31'd0, rsp_valid}, 32'd0);
      chk("async_rst_weight", {16'd0, rsp_weight}, 32'd0);
      chk("async_rst_ready",  {31'd0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      do_rd(7'd5, 1'b0, w, h);
      chk("rd5_after_rst", {16'd0, w}, 32'h224A);

      // randomized traffic, checked by the model every cycle
      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 19);
         ra = AW'(8 * $urandom_range(0, 7));
         if (op < 8) begin
            do_wr(ra, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         end else if (op < 15) begin
            if (op < 11) ra = AW'($urandom_range(0, N_SYN - 1));
            do_rd(ra, 1'($urandom_range(0, 1)), w, h);
         end else if (op == 15) begin
            // kill with a write presented: must not be accepted
            req_valid = 1'b1; req_we = 1'b1; req_rc = 1'b1; req_addr = ra;
            req_wint = 8'($urandom); req_wdeci = 8'($urandom); kill = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0; req_we = 1'b0; req_rc = 1'b0; kill = 1'b0;
            @(posedge clk); #1;
         end else if (op == 16) begin
            req_valid = 1'b1; req_we = 1'b0; req_rc = 1'($urandom_range(0, 1)); req_addr = ra;
            @(posedge clk); #1;
            req_valid = 1'b0; req_rc = 1'b0;
            if ($urandom_range(0, 1) == 1) @(posedge clk);
            #1 kill = 1'b1;
            @(posedge clk); #1 kill = 1'b0;
            repeat (2) @(posedge clk);
            #1;
         end else if (op == 17) begin
            rst = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
